// File: rtl/ibex_efpga_pkg.sv
// ibex_efpga_pkg -- shared types and constants for the Ibex <-> eFPGA bridge.
//   state_e                : bridge FSM states (IDLE, START, WAIT, DONE)
//   op_e                   : 2-bit operator code forwarded to the fabric
//   TIMEOUT_CYCLES_DEFAULT : default fabric wait limit for done-wait mode
//   CNT_W                  : width of the latency/timeout counter
package ibex_efpga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_FN0 = 2'd0,
    OP_FN1 = 2'd1,
    OP_FN2 = 2'd2,
    OP_FN3 = 2'd3
  } op_e;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;
  localparam int          CNT_W                  = 8;

endpackage

// File: rtl/ibex_efpga_cnt.sv
// ibex_efpga_cnt -- 8-bit loadable up/down counter with zero and limit flags.
//   clk, rst  : clock, synchronous active-high reset (clears the count)
//   load      : load load_val (has priority over counting)
//   en, up    : count enable; direction (1 = up, 0 = down)
//   limit     : compare value for at_limit
//   cnt       : current count
//   zero      : cnt == 0
//   at_limit  : cnt == limit
module ibex_efpga_cnt
  import ibex_efpga_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             at_limit
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= up ? cnt + 1'b1 : cnt - 1'b1;
    end
  end

  assign zero     = (cnt == '0);
  assign at_limit = (cnt == limit);

endmodule

// File: rtl/ibex_efpga_bridge.sv
// ibex_efpga_bridge -- hands one operation at a time from the Ibex core to an
// eFPGA fabric and captures the fabric's three results.
//   Parameter TimeoutCycles (1..255): done-wait limit, used only with the
//   EFPGA_TIMEOUT_EN macro defined.
//   Core side   : operand_a_i/operand_b_i/operator_i/delay_i, write_strobe_i,
//                 en_i in; result_a_o/b_o/c_o, fpga_done_o, busy_o, err_o out.
//   Fabric side : fab_operand_a_o/b_o, fab_operator_o, fab_start_o out;
//                 fab_result_a_i/b_i/c_i, fab_done_i in.
//   delay_i != 0 selects fixed latency (DONE exactly delay+1 cycles after
//   START); delay_i == 0 waits for fab_done_i. With EFPGA_TIMEOUT_EN defined,
//   done-wait gives up after TimeoutCycles WAIT cycles and pulses err_o;
//   otherwise err_o is tied to 0 and done-wait waits forever.
module ibex_efpga_bridge
  import ibex_efpga_pkg::*;
#(
  parameter int unsigned TimeoutCycles = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic        write_strobe_i,
  input  logic        en_i,
  input  logic [1:0]  operator_i,
  input  logic [3:0]  delay_i,
  output logic [31:0] result_a_o,
  output logic [31:0] result_b_o,
  output logic [31:0] result_c_o,
  output logic        fpga_done_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [31:0] fab_operand_a_o,
  output logic [31:0] fab_operand_b_o,
  output logic [1:0]  fab_operator_o,
  output logic        fab_start_o,
  input  logic [31:0] fab_result_a_i,
  input  logic [31:0] fab_result_b_i,
  input  logic [31:0] fab_result_c_i,
  input  logic        fab_done_i
);

  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TimeoutCycles - 1);

  state_e      state;
  logic [31:0] op_a;
  logic [31:0] op_b;
  op_e         op;
  logic [3:0]  dly;

  logic             fixed_mode;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_up;
  logic [CNT_W-1:0] cnt_limit;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             cnt_at_limit;
  logic             finish_ok;

  assign fixed_mode = (dly != 4'd0);

  // The counter is loaded on the START->WAIT edge: with D in fixed mode, with
  // 0 in done-wait mode (the latched delay is 0 there, so one path serves both).
  assign cnt_load = (state == ST_START);
  assign cnt_up   = !fixed_mode;
`ifdef EFPGA_TIMEOUT_EN
  assign cnt_en   = (state == ST_WAIT);
`else
  assign cnt_en   = (state == ST_WAIT) && fixed_mode;
`endif
  // Fixed mode leaves WAIT in the cycle the count is 1 (it would hit 0 on that
  // edge); the timeout fires in the cycle the up-count reaches TimeoutCycles-1,
  // i.e. after exactly TimeoutCycles WAIT cycles.
  assign cnt_limit = fixed_mode ? CNT_W'(1) : TO_LIMIT;

  ibex_efpga_cnt u_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (cnt_load),
    .load_val ({{(CNT_W-4){1'b0}}, dly}),
    .en       (cnt_en),
    .up       (cnt_up),
    .limit    (cnt_limit),
    .cnt      (cnt),
    .zero     (cnt_zero),
    .at_limit (cnt_at_limit)
  );

  // Normal completion condition while in WAIT (abort is checked first).
  assign finish_ok = fixed_mode ? (cnt_at_limit || cnt_zero) : fab_done_i;

  assign fab_operand_a_o = op_a;
  assign fab_operand_b_o = op_b;
  assign fab_operator_o  = op;

`ifndef EFPGA_TIMEOUT_EN
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      op_a        <= '0;
      op_b        <= '0;
      op          <= OP_FN0;
      dly         <= '0;
      result_a_o  <= '0;
      result_b_o  <= '0;
      result_c_o  <= '0;
      fab_start_o <= 1'b0;
      fpga_done_o <= 1'b0;
      busy_o      <= 1'b0;
`ifdef EFPGA_TIMEOUT_EN
      err_o       <= 1'b0;
`endif
    end else begin
      fab_start_o <= 1'b0;
      fpga_done_o <= 1'b0;
`ifdef EFPGA_TIMEOUT_EN
      err_o       <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (write_strobe_i && en_i) begin
            op_a        <= operand_a_i;
            op_b        <= operand_b_i;
            op          <= op_e'(operator_i);
            dly         <= delay_i;
            state       <= ST_START;
            fab_start_o <= 1'b1;
            busy_o      <= 1'b1;
          end
        end
        ST_START: begin
          if (!en_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Abort has priority over a simultaneous fab_done_i or timeout.
          if (!en_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else if (finish_ok) begin
            result_a_o  <= fab_result_a_i;
            result_b_o  <= fab_result_b_i;
            result_c_o  <= fab_result_c_i;
            state       <= ST_DONE;
            fpga_done_o <= 1'b1;
          end
`ifdef EFPGA_TIMEOUT_EN
          else if (cnt_at_limit) begin
            state       <= ST_DONE;
            fpga_done_o <= 1'b1;
            err_o       <= 1'b1;
          end
`endif
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_efpga_bridge.sv
// tb_ibex_efpga_bridge -- directed self-checking bench for ibex_efpga_bridge.
// Inputs change 1 time unit after a rising edge; outputs are observed at the
// same point, so each observation shows the state of the current cycle.
module tb_ibex_efpga_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] operand_a, operand_b;
  logic        write_strobe, en;
  logic [1:0]  operator;
  logic [3:0]  delay;
  logic [31:0] result_a, result_b, result_c;
  logic        fpga_done, busy, err;
  logic [31:0] fab_operand_a, fab_operand_b;
  logic [1:0]  fab_operator;
  logic        fab_start;
  logic [31:0] fab_result_a, fab_result_b, fab_result_c;
  logic        fab_done;

  int total = 0;
  int bad   = 0;

`ifdef EFPGA_TIMEOUT_EN
  localparam int unsigned TO_CYC = 16;
`else
  localparam int unsigned TO_CYC = 255;
`endif

  ibex_efpga_bridge #(.TimeoutCycles(TO_CYC)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .operand_a_i     (operand_a),
    .operand_b_i     (operand_b),
    .write_strobe_i  (write_strobe),
    .en_i            (en),
    .operator_i      (operator),
    .delay_i         (delay),
    .result_a_o      (result_a),
    .result_b_o      (result_b),
    .result_c_o      (result_c),
    .fpga_done_o     (fpga_done),
    .busy_o          (busy),
    .err_o           (err),
    .fab_operand_a_o (fab_operand_a),
    .fab_operand_b_o (fab_operand_b),
    .fab_operator_o  (fab_operator),
    .fab_start_o     (fab_start),
    .fab_result_a_i  (fab_result_a),
    .fab_result_b_i  (fab_result_b),
    .fab_result_c_i  (fab_result_c),
    .fab_done_i      (fab_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (result_a !== 32'h0) begin bad++; $display("FAIL reset_result_a: got %h want 0", result_a); end
    total++; if (result_b !== 32'h0) begin bad++; $display("FAIL reset_result_b: got %h want 0", result_b); end
    total++; if (result_c !== 32'h0) begin bad++; $display("FAIL reset_result_c: got %h want 0", result_c); end
    total++; if ({fab_start, fpga_done, busy, err} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b want 0000", {fab_start, fpga_done, busy, err}); end
    total++; if ({fab_operand_a, fab_operand_b, fab_operator} !== 66'h0) begin bad++; $display("FAIL reset_fab_regs: got %h/%h/%h want 0", fab_operand_a, fab_operand_b, fab_operator); end
    rst = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  // Strobe with en_i=0 and a stray fab_done_i in IDLE must both do nothing.
  task automatic test_idle_gating();
    operand_a = 32'h1234; write_strobe = 1'b1; en = 1'b0; fab_done = 1'b1;
    fab_result_a = 32'hBAD0BAD0;
    tick();
    write_strobe = 1'b0; en = 1'b1; fab_done = 1'b0;
    total++; if ({fab_start, busy} !== 2'b00) begin bad++; $display("FAIL gated_strobe: got start/busy %b want 00", {fab_start, busy}); end
    tick();
    total++; if ({fpga_done, busy} !== 2'b00) begin bad++; $display("FAIL idle_fab_done: got done/busy %b want 00", {fpga_done, busy}); end
    total++; if (result_a !== 32'h0) begin bad++; $display("FAIL idle_result: got %h want 0", result_a); end
    total++; if (fab_operand_a !== 32'h0) begin bad++; $display("FAIL gated_latch: got %h want 0", fab_operand_a); end
  endtask

  task automatic test_fixed_latency();
    int done_k = -1;
    int dones = 0;
    int starts = 0;
    operand_a = 32'h5; operand_b = 32'h7; operator = 2'd2; delay = 4'd3;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    total++; if ({fab_start, busy} !== 2'b11) begin bad++; $display("FAIL fixed_start: got start/busy %b want 11", {fab_start, busy}); end
    total++; if ({fab_operand_a, fab_operand_b, fab_operator} !== {32'h5, 32'h7, 2'd2}) begin bad++; $display("FAIL fixed_operands: got %h/%h/%h want 5/7/2", fab_operand_a, fab_operand_b, fab_operator); end
    fab_result_a = 32'h100; fab_result_b = 32'h200; fab_result_c = 32'h300;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (fab_start) starts++;
      if (fpga_done) begin dones++; done_k = k; end
      if (k == 5) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fixed_busy_after: got %b want 0", busy); end
      end
      fab_result_a = 32'h100 + k; fab_result_b = 32'h200 + k; fab_result_c = 32'h300 + k;
    end
    total++; if (done_k !== 4) begin bad++; $display("FAIL fixed_done_cycle: got %0d want 4", done_k); end
    total++; if ({starts, dones} !== {32'd0, 32'd1}) begin bad++; $display("FAIL fixed_pulses: got extra starts %0d dones %0d want 0/1", starts, dones); end
    total++; if ({result_a, result_b, result_c} !== {32'h103, 32'h203, 32'h303}) begin bad++; $display("FAIL fixed_results: got %h/%h/%h want 103/203/303", result_a, result_b, result_c); end
    total++; if (fab_operand_a !== 32'h5) begin bad++; $display("FAIL fixed_operand_hold: got %h want 5", fab_operand_a); end
  endtask

  task automatic test_done_wait();
    int done_k = -1;
    operand_a = 32'hA; delay = 4'd0; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    fab_result_a = 32'hCAFEF00D; fab_result_b = 32'h1; fab_result_c = 32'h2;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (fpga_done && done_k < 0) done_k = k;
      fab_done = (k == 10);
    end
    total++; if (done_k !== 11) begin bad++; $display("FAIL dwait_done_cycle: got %0d want 11", done_k); end
    total++; if (result_a !== 32'hCAFEF00D) begin bad++; $display("FAIL dwait_result_a: got %h want cafef00d", result_a); end
  endtask

  task automatic test_back_to_back();
    int done_k = -1;
    int dones = 0;
    int starts = 0;
    operand_a = 32'h11; delay = 4'd5; write_strobe = 1'b1;
    fab_result_a = 32'hA1; fab_result_b = 32'hB2; fab_result_c = 32'hC3;
    tick();
    write_strobe = 1'b0;
    if (fab_start) starts++;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (fab_start) starts++;
      if (fpga_done) begin dones++; done_k = k; end
      if (k == 2) begin operand_a = 32'h99; write_strobe = 1'b1; end
      if (k == 3) write_strobe = 1'b0;
    end
    total++; if (starts !== 1) begin bad++; $display("FAIL b2b_starts: got %0d want 1", starts); end
    total++; if (dones !== 1 || done_k !== 6) begin bad++; $display("FAIL b2b_done: got count %0d at %0d want 1 at 6", dones, done_k); end
    total++; if (fab_operand_a !== 32'h11) begin bad++; $display("FAIL b2b_operand: got %h want 11", fab_operand_a); end
    total++; if (result_a !== 32'hA1) begin bad++; $display("FAIL b2b_result: got %h want a1", result_a); end
  endtask

  task automatic test_abort();
    int dones = 0;
    delay = 4'd0; write_strobe = 1'b1;
    fab_result_a = 32'hDEAD0001; fab_result_b = 32'hDEAD0002; fab_result_c = 32'hDEAD0003;
    tick();
    write_strobe = 1'b0;
    tick();
    tick();
    en = 1'b0; fab_done = 1'b1;
    tick();
    fab_done = 1'b0;
    total++; if ({busy, fpga_done} !== 2'b00) begin bad++; $display("FAIL abort_busy_done: got %b want 00", {busy, fpga_done}); end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (fpga_done) dones++;
    end
    en = 1'b1;
    total++; if (dones !== 0) begin bad++; $display("FAIL abort_late_done: got %0d want 0", dones); end
    total++; if ({result_a, result_b, result_c} !== {32'hA1, 32'hB2, 32'hC3}) begin bad++; $display("FAIL abort_results: got %h/%h/%h want a1/b2/c3", result_a, result_b, result_c); end
  endtask

  task automatic test_timeout();
    delay = 4'd0; write_strobe = 1'b1; fab_done = 1'b0;
    tick();
    write_strobe = 1'b0;
`ifdef EFPGA_TIMEOUT_EN
    begin
      int done_k = -1;
      int err_k = -1;
      for (int k = 1; k <= 30; k++) begin
        tick();
        if (fpga_done && done_k < 0) done_k = k;
        if (err && err_k < 0) err_k = k;
      end
      total++; if (done_k !== 17) begin bad++; $display("FAIL timeout_done_cycle: got %0d want 17", done_k); end
      total++; if (err_k !== 17) begin bad++; $display("FAIL timeout_err_cycle: got %0d want 17", err_k); end
      total++; if (result_a !== 32'hA1) begin bad++; $display("FAIL timeout_results: got %h want a1", result_a); end
    end
`else
    begin
      int idle_cycles = 0;
      int dones = 0;
      for (int k = 1; k <= 310; k++) begin
        tick();
        if (!busy) idle_cycles++;
        if (fpga_done) dones++;
      end
      total++; if ({idle_cycles, dones} !== 64'h0) begin bad++; $display("FAIL no_timeout_wait: got idle %0d dones %0d want 0/0", idle_cycles, dones); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL no_timeout_err: got %b want 0", err); end
      en = 1'b0;
      tick();
      en = 1'b1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL no_timeout_abort: got busy %b want 0", busy); end
    end
`endif
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    operand_a = 32'h77; delay = 4'd0; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({result_a, result_b, result_c, fab_operand_a, fab_operand_b} !== 160'h0) begin bad++; $display("FAIL rstmid_data: got res %h op %h want 0", result_a, fab_operand_a); end
    total++; if ({fab_start, fpga_done, busy, err, fab_operator} !== 6'b0) begin bad++; $display("FAIL rstmid_flags: got %b want 0", {fab_start, fpga_done, busy, err, fab_operator}); end
    fab_done = 1'b1;
    tick();
    fab_done = 1'b0;
    if (fpga_done) dones++;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (fpga_done) dones++;
    end
    total++; if ({dones, 31'd0, busy} !== 64'h0) begin bad++; $display("FAIL rstmid_late_done: got dones %0d busy %b want 0/0", dones, busy); end
  endtask

  initial begin
    rst = 1'b0; operand_a = '0; operand_b = '0; write_strobe = 1'b0; en = 1'b1;
    operator = '0; delay = '0; fab_result_a = '0; fab_result_b = '0;
    fab_result_c = '0; fab_done = 1'b0;
    test_reset();
    test_idle_gating();
    test_fixed_latency();
    test_done_wait();
    test_back_to_back();
    test_abort();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
